rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Single write-port arbiter and scoreboard in front of the 32x32 integer register file.
- Merges two result sources onto one registered write port (wen/wraddr/wrdata):
  - single-cycle ALU results (port A)
  - long-latency load/mul-div results (port B)
- Tracks registers with outstanding long-latency writes so decode can stall on RAW hazards.

Parameters:
- STARVE_MAX, 4: consecutive cycles port A may be blocked by port B before A is granted once.
- XLEN, 32: data width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  ALU result valid
- a_ready  out  1  ALU result accepted this cycle
- a_rd  in  5  ALU destination register
- a_data  in  XLEN  ALU result
- b_valid  in  1  long-latency result valid
- b_ready  out  1  long-latency result accepted this cycle
- b_rd  in  5  long-latency destination register
- b_data  in  XLEN  long-latency result
- sb_set  in  1  decode issues a long-latency op writing sb_rd
- sb_rd  in  5  register to mark busy
- rs1  in  5  decode source 1 lookup
- rs2  in  5  decode source 2 lookup
- rs_busy  out  1  rs1 or rs2 is marked busy (combinational)
- wen  out  1  register-file write enable
- wraddr  out  5  register-file write address
- wrdata  out  XLEN  register-file write data

Behaviour:
- Reset (async, active-high): wen=0, wraddr=0, wrdata=0, scoreboard all clear, starve counter=0. a_ready/b_ready are 0 while rst is high.
- Grant rule, combinational each cycle:
  - B wins if b_valid, unless the starve counter has reached STARVE_MAX and a_valid is high; then A wins.
  - A wins if a_valid and B does not win.
  - a_ready and b_ready are one-hot or zero. Ready never depends on rd or data.
- Transfer = valid && ready. Each source holds valid/rd/data stable until its transfer.
- Output register: the cycle after a transfer, wen=1 and wraddr/wrdata carry the granted source; otherwise wen=0. Latency is exactly 1 cycle; throughput is 1 write per cycle.
- x0: a transfer with rd=0 completes the handshake but produces wen=0 the next cycle. The scoreboard ignores sb_set with sb_rd=0.
- Starve counter:
  - Increments when a_valid && !a_ready, saturating at STARVE_MAX.
  - Clears on an A transfer or when a_valid=0.
  - With STARVE_MAX=4, A is granted on the 5th contested cycle.
- Scoreboard (32 bits):
  - sb_set marks busy[sb_rd] on the next edge.
  - A B transfer clears busy[b_rd] on the next edge.
  - Same-cycle set and clear of the same register: set wins (new issue supersedes).
  - rs_busy = busy[rs1] | busy[rs2]. It reflects registered state only; the register file's write-through path covers the commit cycle.
- Reset mid-transfer: the pending output write is discarded (wen forced 0) and the scoreboard is cleared.

Optional Feature:
- Macro: RF_WB_PERF_EN.
- Defined:
  - Adds outputs perf_conflict (32) and perf_starve (32).
  - perf_conflict increments each cycle both a_valid and b_valid are high.
  - perf_starve increments each cycle A is granted by the starvation rule.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor the counter logic exists; the block behaves identically otherwise.

Decomposition:
- Shared defines header:
  - register-index width (5) and XLEN default
  - x0 index constant
  - STARVE_MAX default
- One sub-module, rf_scoreboard: 32-bit busy vector with set/clear/lookup and set-over-clear priority.
- Arbiter, starve counter and output register stay in rf_writeback.

Test Plan:
- Single A write: a_valid=1, a_rd=5, a_data=0xDEADBEEF, b idle -> a_ready=1 same cycle; next cycle wen=1, wraddr=5, wrdata=0xDEADBEEF; then wen=0.
- Conflict: A (rd=3, 0x11) and B (rd=7, 0x22) valid together -> B granted first (wraddr=7), A written the following cycle (wraddr=3).
- Starvation, STARVE_MAX=4: b_valid held high with new data every cycle, a_valid high -> A blocked 4 cycles, granted on cycle 5; B resumes on cycle 6.
- x0 drop: b_rd=0, b_data=0x55 -> b_ready=1, next cycle wen=0. sb_set with sb_rd=0 -> rs_busy stays 0 for rs1=0.
- Scoreboard: sb_set rd=9 -> next cycle rs1=9 gives rs_busy=1; B commit rd=9 -> rs_busy=0 one cycle after the transfer. Same-cycle sb_set rd=9 with B clear rd=9 -> busy remains 1.
- Async reset: assert rst between clock edges during a pending write -> wen, wraddr, wrdata drop to 0 immediately, all busy bits clear, both readies 0 until rst deasserts.

Source files
------------

// File: rtl/rf_writeback_pkg.sv
// ============================================================================
// Module      : rf_writeback_pkg
// Description : Shared widths and constants for the register-file writeback
//               arbiter and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_writeback_pkg;

    localparam int             REG_IDX_W      = 5;
    localparam int             NUM_REGS       = 32;
    localparam int             XLEN_DEF       = 32;
    localparam int             STARVE_MAX_DEF = 4;
    localparam logic [4:0]     X0_IDX         = 5'd0;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : 32-entry busy vector tracking outstanding long-latency writes;
//               a set in the same cycle as a clear of the same register wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_writeback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_rd,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear applied before set so a new issue supersedes a retiring write.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != X0_IDX)) begin
            busy_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs_busy = busy_q[rs1] | busy_q[rs2];

endmodule

`default_nettype wire

// File: rtl/rf_writeback.sv
// ============================================================================
// Module      : rf_writeback
// Description : Single write-port arbiter (ALU vs long-latency results) with
//               starvation guard, registered RF write port and scoreboard.
//               Optional perf counters enabled by macro RF_WB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int XLEN       = XLEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [REG_IDX_W-1:0] a_rd,
    input  logic [XLEN-1:0]      a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [REG_IDX_W-1:0] b_rd,
    input  logic [XLEN-1:0]      b_data,
    input  logic                 sb_set,
    input  logic [REG_IDX_W-1:0] sb_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs_busy,
    output logic                 wen,
    output logic [REG_IDX_W-1:0] wraddr,
`ifdef RF_WB_PERF_EN
    output logic [XLEN-1:0]      wrdata,
    output logic [31:0]          perf_conflict,
    output logic [31:0]          perf_starve
`else
    output logic [XLEN-1:0]      wrdata
`endif
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 wen_q, wen_d;
    logic [REG_IDX_W-1:0] wraddr_q, wraddr_d;
    logic [XLEN-1:0]      wrdata_q, wrdata_d;

    logic starve_hit;
    logic a_grant, b_grant;
    logic a_xfer, b_xfer;

    always_comb begin
        starve_hit = a_valid && (starve_q == STARVE_W'(STARVE_MAX));
        b_grant    = b_valid && !starve_hit;
        a_grant    = a_valid && !b_grant;
        a_ready    = a_grant && !rst;
        b_ready    = b_grant && !rst;
        a_xfer     = a_valid && a_ready;
        b_xfer     = b_valid && b_ready;
    end

    always_comb begin
        starve_d = starve_q;
        if (!a_valid || a_xfer) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_comb begin
        wen_d    = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        if (a_xfer && (a_rd != X0_IDX)) begin
            wen_d    = 1'b1;
            wraddr_d = a_rd;
            wrdata_d = a_data;
        end else if (b_xfer && (b_rd != X0_IDX)) begin
            wen_d    = 1'b1;
            wraddr_d = b_rd;
            wrdata_d = b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign wen    = wen_q;
    assign wraddr = wraddr_q;
    assign wrdata = wrdata_q;

    rf_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (sb_set),
        .set_rd  (sb_rd),
        .clr_en  (b_xfer),
        .clr_rd  (b_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs_busy (rs_busy)
    );

`ifdef RF_WB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    // A starvation grant is one where B was also asking.
    always_comb begin
        perf_conflict_d = perf_conflict_q + {31'd0, (a_valid && b_valid)};
        perf_starve_d   = perf_starve_q + {31'd0, (a_xfer && b_valid)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_q <= '0;
            perf_starve_q   <= '0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_starve_q   <= perf_starve_d;
        end
    end

    assign perf_conflict = perf_conflict_q;
    assign perf_starve   = perf_starve_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback.sv
// ============================================================================
// Module      : tb_rf_writeback
// Description : Directed self-checking bench for rf_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, sb_rd, rs1, rs2, wraddr;
    logic [31:0] a_data, b_data, wrdata;
    logic        sb_set, rs_busy, wen;
`ifdef RF_WB_PERF_EN
    logic [31:0] perf_conflict, perf_starve;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_writeback dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .sb_set  (sb_set),
        .sb_rd   (sb_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs_busy (rs_busy),
        .wen     (wen),
        .wraddr  (wraddr),
`ifdef RF_WB_PERF_EN
        .wrdata        (wrdata),
        .perf_conflict (perf_conflict),
        .perf_starve   (perf_starve)
`else
        .wrdata  (wrdata)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        sb_set = 1'b0; sb_rd = '0; rs1 = '0; rs2 = '0;

        // Reset state, readies suppressed even with both sources valid
        tick();
        tick();
        check("rst_wen",     {31'd0, wen}, 32'd0);
        check("rst_wraddr",  {27'd0, wraddr}, 32'd0);
        check("rst_wrdata",  wrdata, 32'd0);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_rs_busy", {31'd0, rs_busy}, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single A write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        check("a_single_ready",   {31'd0, a_ready}, 32'd1);
        check("a_single_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("a_single_wen",    {31'd0, wen}, 32'd1);
        check("a_single_wraddr", {27'd0, wraddr}, 32'd5);
        check("a_single_wrdata", wrdata, 32'hDEADBEEF);
        tick();
        check("a_single_wen_off", {31'd0, wen}, 32'd0);

        // Conflict: B first, then A
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h22;
        #1;
        check("conf_b_ready", {31'd0, b_ready}, 32'd1);
        check("conf_a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        b_valid = 1'b0;
        check("conf_wraddr_b", {27'd0, wraddr}, 32'd7);
        check("conf_wrdata_b", wrdata, 32'h22);
        #1;
        check("conf_a_ready2", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("conf_wen_a",    {31'd0, wen}, 32'd1);
        check("conf_wraddr_a", {27'd0, wraddr}, 32'd3);
        check("conf_wrdata_a", wrdata, 32'h11);
        tick();
        check("conf_wen_off", {31'd0, wen}, 32'd0);

        // Starvation: four B wins, A on the fifth, B again on the sixth
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'hAA;
        b_valid = 1'b1; b_rd = 5'd10;
        for (int c = 1; c <= 4; c++) begin
            b_data = 32'h100 + c;
            #1;
            check("starve_b_ready", {31'd0, b_ready}, 32'd1);
            check("starve_a_block", {31'd0, a_ready}, 32'd0);
            tick();
            check("starve_b_wraddr", {27'd0, wraddr}, 32'd10);
            check("starve_b_wrdata", wrdata, 32'h100 + c);
        end
        b_data = 32'h105;
        #1;
        check("starve_a_grant", {31'd0, a_ready}, 32'd1);
        check("starve_b_held",  {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("starve_a_wraddr", {27'd0, wraddr}, 32'd4);
        check("starve_a_wrdata", wrdata, 32'hAA);
        #1;
        check("starve_b_resume", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("starve_b6_wraddr", {27'd0, wraddr}, 32'd10);
        check("starve_b6_wrdata", wrdata, 32'h105);
`ifdef RF_WB_PERF_EN
        check("perf_conflict", perf_conflict, 32'd6);
        check("perf_starve",   perf_starve, 32'd1);
`endif

        // x0 drop
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h55;
        #1;
        check("x0_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("x0_wen", {31'd0, wen}, 32'd0);
        sb_set = 1'b1; sb_rd = 5'd0;
        tick();
        sb_set = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        #1;
        check("x0_sb_ignored", {31'd0, rs_busy}, 32'd0);

        // Scoreboard set, lookup via both ports, clear on B commit
        sb_set = 1'b1; sb_rd = 5'd9;
        tick();
        sb_set = 1'b0; rs1 = 5'd9; rs2 = 5'd0;
        #1;
        check("sb_busy_rs1", {31'd0, rs_busy}, 32'd1);
        rs1 = 5'd0; rs2 = 5'd9;
        #1;
        check("sb_busy_rs2", {31'd0, rs_busy}, 32'd1);
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        tick();
        b_valid = 1'b0;
        check("sb_clear", {31'd0, rs_busy}, 32'd0);
        check("sb_commit_wraddr", {27'd0, wraddr}, 32'd9);
        check("sb_commit_wrdata", wrdata, 32'h99);

        // Same-cycle set and clear: set wins
        sb_set = 1'b1; sb_rd = 5'd9;
        tick();
        check("sb_reset_busy", {31'd0, rs_busy}, 32'd1);
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9A;
        tick();
        sb_set = 1'b0; b_valid = 1'b0;
        check("sb_set_wins", {31'd0, rs_busy}, 32'd1);

        // Async reset during a pending write
        a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h77;
        tick();
        check("arst_pending_wen", {31'd0, wen}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wen",     {31'd0, wen}, 32'd0);
        check("arst_wraddr",  {27'd0, wraddr}, 32'd0);
        check("arst_wrdata",  wrdata, 32'd0);
        check("arst_busy",    {31'd0, rs_busy}, 32'd0);
        b_valid = 1'b1;
        #1;
        check("arst_a_ready", {31'd0, a_ready}, 32'd0);
        check("arst_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        check("arst_hold_wen", {31'd0, wen}, 32'd0);
        check("arst_hold_a_ready", {31'd0, a_ready}, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
